// File: rtl/flt_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency floating-point core among NUM_REQ requesters.
// Define FLT_PIPE_ARBITER_LATENCY_CHECK_EN to enable the sticky core-latency mismatch flag.
module flt_pipe_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TDATA_WIDTH    = 32,
    parameter int PIPE_STAGE_NUM = 14
) (
    input  logic                           i_aclk,
    input  logic                           i_areset,
    input  logic [NUM_REQ*TDATA_WIDTH-1:0] i_req_tdata,
    input  logic [NUM_REQ-1:0]             i_req_tvalid,
    output logic [NUM_REQ-1:0]             o_req_tready,
    output logic [TDATA_WIDTH-1:0]         o_core_a_tdata,
    output logic                           o_core_tvalid,
    input  logic [TDATA_WIDTH-1:0]         i_core_result_tdata,
    input  logic                           i_core_result_tvalid,
    output logic [TDATA_WIDTH-1:0]         o_rsp_tdata,
    output logic [NUM_REQ-1:0]             o_rsp_tvalid,
    output logic                           o_busy,
    output logic                           o_err_latency
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(PIPE_STAGE_NUM + 3);

    logic [ID_W-1:0]        prio_reg;
    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        grant_id;
    logic [TDATA_WIDTH-1:0] grant_data;
    logic                   grant_found;
    logic                   accept;
    int                     rr_idx;

    logic                   core_tvalid_reg;
    logic [ID_W-1:0]        core_id_reg;
    logic [TDATA_WIDTH-1:0] core_a_tdata_reg;

    logic                   tag_valid_reg [PIPE_STAGE_NUM];
    logic [ID_W-1:0]        tag_id_reg    [PIPE_STAGE_NUM];
    logic                   tag_out_valid;
    logic [ID_W-1:0]        tag_out_id;

    logic [NUM_REQ-1:0]     rsp_tvalid_reg;
    logic [TDATA_WIDTH-1:0] rsp_tdata_reg;
    logic                   rsp_any;
    logic [CNT_W-1:0]       inflight_cnt_reg;

    // Search starts at prio_reg, which always points one past the last accepted requester.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_data  = '0;
        grant_found = 1'b0;
        rr_idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = (int'(prio_reg) + i) % NUM_REQ;
            if (!grant_found && !i_areset && i_req_tvalid[rr_idx]) begin
                grant_found    = 1'b1;
                grant[rr_idx]  = 1'b1;
                grant_id       = ID_W'(rr_idx);
                grant_data     = i_req_tdata[rr_idx*TDATA_WIDTH +: TDATA_WIDTH];
            end
        end
    end

    assign accept = grant_found;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            prio_reg         <= '0;
            core_tvalid_reg  <= 1'b0;
            core_id_reg      <= '0;
            core_a_tdata_reg <= '0;
        end else begin
            core_tvalid_reg <= accept;
            if (accept) begin
                prio_reg         <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                core_id_reg      <= grant_id;
                core_a_tdata_reg <= grant_data;
            end
        end
    end

    // Tag pipe mirrors the core so results are routed without trusting core tvalid.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STAGE_NUM; gi++) begin : g_tag
            always_ff @(posedge i_aclk or posedge i_areset) begin
                if (i_areset) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else if (gi == 0) begin
                    tag_valid_reg[gi] <= core_tvalid_reg;
                    tag_id_reg[gi]    <= core_id_reg;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[(gi == 0) ? 0 : gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign tag_out_valid = tag_valid_reg[PIPE_STAGE_NUM-1];
    assign tag_out_id    = tag_id_reg[PIPE_STAGE_NUM-1];

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            rsp_tvalid_reg <= '0;
            rsp_tdata_reg  <= '0;
        end else begin
            rsp_tvalid_reg <= '0;
            if (tag_out_valid) begin
                rsp_tvalid_reg <= NUM_REQ'(1) << tag_out_id;
                rsp_tdata_reg  <= i_core_result_tdata;
            end
        end
    end

    assign rsp_any = |rsp_tvalid_reg;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            inflight_cnt_reg <= '0;
        end else if (accept && !rsp_any) begin
            inflight_cnt_reg <= inflight_cnt_reg + CNT_W'(1);
        end else if (!accept && rsp_any) begin
            inflight_cnt_reg <= inflight_cnt_reg - CNT_W'(1);
        end
    end

`ifdef FLT_PIPE_ARBITER_LATENCY_CHECK_EN
    logic err_latency_reg;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            err_latency_reg <= 1'b0;
        end else if (i_core_result_tvalid != tag_out_valid) begin
            err_latency_reg <= 1'b1;
        end
    end

    assign o_err_latency = err_latency_reg;
`else
    logic unused_core_result_tvalid;

    assign unused_core_result_tvalid = i_core_result_tvalid;
    assign o_err_latency             = 1'b0;
`endif

    assign o_req_tready   = grant;
    assign o_core_tvalid  = core_tvalid_reg;
    assign o_core_a_tdata = core_a_tdata_reg;
    assign o_rsp_tvalid   = rsp_tvalid_reg;
    assign o_rsp_tdata    = rsp_tdata_reg;
    assign o_busy         = (inflight_cnt_reg != '0);

endmodule

// File: tb/tb_flt_pipe_arbiter.sv
// Scoreboard bench for flt_pipe_arbiter with a behavioural fixed-latency core model.
module tb_flt_pipe_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int P = 14;

    logic           i_aclk = 1'b0;
    logic           i_areset = 1'b1;
    logic [N*W-1:0] i_req_tdata = '0;
    logic [N-1:0]   i_req_tvalid = '0;
    logic [N-1:0]   o_req_tready;
    logic [W-1:0]   o_core_a_tdata;
    logic           o_core_tvalid;
    logic [W-1:0]   i_core_result_tdata;
    logic           i_core_result_tvalid;
    logic [W-1:0]   o_rsp_tdata;
    logic [N-1:0]   o_rsp_tvalid;
    logic           o_busy;
    logic           o_err_latency;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int core_lat     = 14;
    bit ignore_rsp   = 1'b0;

    typedef struct {
        int         id;
        logic [W-1:0] data;
        int         due;
    } sb_t;
    sb_t sb_q[$];

    logic         pv [16];
    logic [W-1:0] pd [16];

    flt_pipe_arbiter #(.NUM_REQ(N), .TDATA_WIDTH(W), .PIPE_STAGE_NUM(P)) dut (
        .i_aclk               (i_aclk),
        .i_areset             (i_areset),
        .i_req_tdata          (i_req_tdata),
        .i_req_tvalid         (i_req_tvalid),
        .o_req_tready         (o_req_tready),
        .o_core_a_tdata       (o_core_a_tdata),
        .o_core_tvalid        (o_core_tvalid),
        .i_core_result_tdata  (i_core_result_tdata),
        .i_core_result_tvalid (i_core_result_tvalid),
        .o_rsp_tdata          (o_rsp_tdata),
        .o_rsp_tvalid         (o_rsp_tvalid),
        .o_busy               (o_busy),
        .o_err_latency        (o_err_latency)
    );

    always #5 i_aclk = ~i_aclk;

    always @(posedge i_aclk) cyc <= cyc + 1;

    function automatic logic [W-1:0] core_fn(input logic [W-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_5A5A;
    endfunction

    // Core model: not reset, so results issued before a reset still emerge afterwards.
    always @(posedge i_aclk) begin
        pv[0] <= o_core_tvalid;
        pd[0] <= core_fn(o_core_a_tdata);
        for (int i = 1; i < 16; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign i_core_result_tvalid = pv[core_lat-1];
    assign i_core_result_tdata  = pd[core_lat-1];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge i_aclk) begin
        sb_t e;
        if (!i_areset) begin
            check_val("tready_onehot0", 32'($onehot0(o_req_tready)), 32'd1);
            check_val("tready_no_valid", 32'(o_req_tready & ~i_req_tvalid), 32'd0);
            for (int k = 0; k < N; k++) begin
                if (i_req_tvalid[k] && o_req_tready[k]) begin
                    e.id   = k;
                    e.data = core_fn(i_req_tdata[k*W +: W]);
                    e.due  = cyc + P + 2;
                    sb_q.push_back(e);
                    $display("[TB] accept req=%0d operand=%08h cycle=%0d", k, i_req_tdata[k*W +: W], cyc);
                end
            end
            if (o_rsp_tvalid != '0) begin
                if (ignore_rsp) begin
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                end else if (sb_q.size() == 0) begin
                    check_val("rsp_unexpected", 32'(o_rsp_tvalid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("rsp_id", 32'(o_rsp_tvalid), 32'(1) << e.id);
                    check_val("rsp_data", o_rsp_tdata, e.data);
                    check_val("rsp_cycle", 32'(cyc), 32'(e.due));
                    $display("[TB] response req=%0d data=%08h cycle=%0d", e.id, o_rsp_tdata, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge i_aclk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        step();
        i_areset     = 1'b1;
        i_req_tvalid = '0;
        sb_q.delete();
        repeat (cycles) @(posedge i_aclk);
        #1;
        i_areset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge i_aclk);
        check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) i_req_tdata[k*W +: W] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state, with all requesters asserting valid to prove tready is gated.
        i_areset     = 1'b1;
        i_req_tvalid = '1;
        rand_data();
        repeat (20) @(posedge i_aclk);
        @(negedge i_aclk);
        check_val("rst_tready", 32'(o_req_tready), 32'd0);
        check_val("rst_core_tvalid", 32'(o_core_tvalid), 32'd0);
        check_val("rst_core_data", o_core_a_tdata, 32'd0);
        check_val("rst_rsp_tvalid", 32'(o_rsp_tvalid), 32'd0);
        check_val("rst_rsp_data", o_rsp_tdata, 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_err", 32'(o_err_latency), 32'd0);
        step();
        i_areset     = 1'b0;
        i_req_tvalid = '0;

        // Single request from requester 2.
        step();
        i_req_tdata[2*W +: W] = 32'h3F80_0000;
        i_req_tvalid          = 4'b0100;
        @(negedge i_aclk);
        check_val("single_grant", 32'(o_req_tready), 32'h4);
        for (int t = 1; t <= 18; t++) begin
            step();
            i_req_tvalid = '0;
            @(negedge i_aclk);
            check_val("single_core_tvalid", 32'(o_core_tvalid), (t == 1) ? 32'd1 : 32'd0);
            if (t == 1) check_val("single_core_data", o_core_a_tdata, 32'h3F80_0000);
            check_val("single_busy", 32'(o_busy), (t <= 16) ? 32'd1 : 32'd0);
            check_val("single_rsp_tvalid", 32'(o_rsp_tvalid), (t == 16) ? 32'h4 : 32'h0);
            if (t >= 16) check_val("single_rsp_data", o_rsp_tdata, core_fn(32'h3F80_0000));
        end

        // Full contention: grant order 0,1,2,3,0,1,2,3.
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            step();
            rand_data();
            i_req_tvalid = 4'b1111;
            @(negedge i_aclk);
            check_val("contend_grant", 32'(o_req_tready), 32'(1) << (i % 4));
        end
        step();
        i_req_tvalid = '0;
        drain();
        check_val("contend_err", 32'(o_err_latency), 32'd0);

        // Fairness: after requester 3, requester 0 wins over 3.
        do_reset(1);
        step();
        rand_data();
        i_req_tvalid = 4'b1000;
        @(negedge i_aclk);
        check_val("fair_first", 32'(o_req_tready), 32'h8);
        step();
        rand_data();
        i_req_tvalid = 4'b1001;
        @(negedge i_aclk);
        check_val("fair_wrap", 32'(o_req_tready), 32'h1);
        step();
        i_req_tvalid = 4'b1000;
        @(negedge i_aclk);
        check_val("fair_then3", 32'(o_req_tready), 32'h8);
        step();
        i_req_tvalid = '0;
        drain();

        // Accept and response in the same cycle with three in flight.
        do_reset(1);
        for (int t = 0; t <= 17; t++) begin
            step();
            rand_data();
            i_req_tvalid = (t < 3 || t == 16) ? 4'b0001 : 4'b0000;
            @(negedge i_aclk);
            if (t == 16) begin
                check_val("simul_accept", 32'(o_req_tready), 32'h1);
                check_val("simul_rsp", 32'(o_rsp_tvalid), 32'h1);
            end
            if (t == 17) begin
                check_val("simul_count", 32'(dut.inflight_cnt_reg), 32'd3);
                check_val("simul_busy", 32'(o_busy), 32'd1);
            end
        end
        step();
        i_req_tvalid = '0;
        drain();

        // Mid-stream reset discards five in-flight operations.
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            step();
            rand_data();
            i_req_tvalid = 4'b1111;
        end
        step();
        i_req_tvalid = '0;
        repeat (3) step();
        do_reset(1);
        @(negedge i_aclk);
        check_val("midrst_count", 32'(dut.inflight_cnt_reg), 32'd0);
        check_val("midrst_busy", 32'(o_busy), 32'd0);
        repeat (22) @(negedge i_aclk);
        check_val("midrst_quiet_busy", 32'(o_busy), 32'd0);
        step();
        rand_data();
        i_req_tvalid = 4'b1111;
        @(negedge i_aclk);
        check_val("midrst_next_grant", 32'(o_req_tready), 32'h1);
        step();
        i_req_tvalid = '0;
        drain();

        // Latency mismatch: core model one cycle short.
        do_reset(1);
        core_lat   = 13;
        ignore_rsp = 1'b1;
        step();
        rand_data();
        i_req_tvalid = 4'b0001;
        step();
        i_req_tvalid = '0;
        repeat (18) @(negedge i_aclk);
`ifdef FLT_PIPE_ARBITER_LATENCY_CHECK_EN
        check_val("latchk_set", 32'(o_err_latency), 32'd1);
        repeat (5) @(negedge i_aclk);
        check_val("latchk_held", 32'(o_err_latency), 32'd1);
`else
        check_val("latchk_off", 32'(o_err_latency), 32'd0);
        repeat (5) @(negedge i_aclk);
        check_val("latchk_off_held", 32'(o_err_latency), 32'd0);
`endif
        do_reset(1);
        core_lat   = 14;
        ignore_rsp = 1'b0;
        repeat (20) @(negedge i_aclk);
        check_val("latchk_cleared", 32'(o_err_latency), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/flt_pipe_arbiter.md
FLT_PIPE_ARBITER -- requirements
Module: flt_pipe_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one floating-point core (2..8).
REQ-002 SHALL have parameter TDATA_WIDTH, default 32, operand and result width.
REQ-003 SHALL have parameter PIPE_STAGE_NUM, default 14, fixed core latency in cycles from core tvalid in to core result tvalid out.
REQ-004 SHALL have port i_aclk  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port i_areset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_req_tdata  input  NUM_REQ*TDATA_WIDTH  operand per requester; requester k occupies slice k.
REQ-007 SHALL have port i_req_tvalid  input  NUM_REQ  per-requester operand valid.
REQ-008 SHALL have port o_req_tready  output  NUM_REQ  per-requester grant; one-hot or zero.
REQ-009 SHALL have port o_core_a_tdata  output  TDATA_WIDTH  operand to core.
REQ-010 SHALL have port o_core_tvalid  output  1  operand valid to core.
REQ-011 SHALL have port i_core_result_tdata  input  TDATA_WIDTH  core result.
REQ-012 SHALL have port i_core_result_tvalid  input  1  core result valid.
REQ-013 SHALL have port o_rsp_tdata  output  TDATA_WIDTH  result, broadcast to all requesters.
REQ-014 SHALL have port o_rsp_tvalid  output  NUM_REQ  one-hot result valid, identifying the owning requester.
REQ-015 SHALL have port o_busy  output  1  high while any operation is in flight.
REQ-016 SHALL have port o_err_latency  output  1  sticky latency-mismatch flag (see Configuration).

Function
REQ-017 SHALL grant round-robin: the search starts at the requester after the last accepted one; with no prior accept, requester 0 has priority.
REQ-018 SHALL drive o_req_tready combinationally from i_req_tvalid and the round-robin pointer; at most one bit high; zero when no tvalid is high.
REQ-019 SHALL accept an operand when i_req_tvalid[k] and o_req_tready[k] are both high; at most one accept per cycle.
REQ-020 SHALL register the accepted operand: o_core_tvalid=1 and o_core_a_tdata=slice k in the cycle after the accept; otherwise o_core_tvalid=0 and o_core_a_tdata holds.
REQ-021 SHALL advance the round-robin pointer only on an accept.
REQ-022 SHALL push {valid, requester id} into a PIPE_STAGE_NUM-deep tag shift register alongside each issued o_core_tvalid; a bubble pushes valid=0.
REQ-023 SHALL assert o_rsp_tvalid[id] and drive o_rsp_tdata=i_core_result_tdata, both registered, in the cycle after the tag output is valid; total latency from accept to o_rsp_tvalid is PIPE_STAGE_NUM+2 cycles.
REQ-024 SHALL sustain one accept per cycle with no back-to-back bubbles.
REQ-025 SHALL keep an in-flight counter of width ceil(log2(PIPE_STAGE_NUM+3)); it increments on accept and decrements on o_rsp_tvalid; when both occur in one cycle it holds. o_busy is high when the counter is nonzero.
REQ-026 SHALL hold o_rsp_tdata when no response is valid.

Reset
REQ-027 SHALL, while i_areset=1, clear the pointer (requester 0 priority), the tag register, the counter and o_err_latency, and drive o_core_tvalid, o_rsp_tvalid, o_busy and o_req_tready to 0. Data registers SHALL be 0.
REQ-028 SHALL discard operations in flight at a mid-stream reset; core results arriving after reset release SHALL produce no o_rsp_tvalid.

Configuration
REQ-029 SHALL support macro FLT_PIPE_ARBITER_LATENCY_CHECK_EN. When it is defined, o_err_latency SHALL set, and stay set until reset, on any cycle where i_core_result_tvalid differs from the tag-output valid bit. When it is undefined, o_err_latency SHALL be constant 0 and the compare logic SHALL be absent. Routing SHALL always use the tag, never i_core_result_tvalid.

Verification
REQ-030 SHALL cover single request: requester 2 valid with 0x3F800000 and a model core of latency 14 -> o_core_tvalid at +1, o_rsp_tvalid=4'b0100 at +16 with the model result, o_busy high for cycles +1..+16.
REQ-031 SHALL cover full contention: all 4 valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one accept per cycle, responses in the same order with no gaps.
REQ-032 SHALL cover the fairness pointer: accept requester 3, then requesters 0 and 3 both valid -> requester 0 granted first.
REQ-033 SHALL cover reset mid-stream: 5 operations in flight, then i_areset pulsed for 1 cycle -> no o_rsp_tvalid for the stale results, counter 0, next accept from requester 0.
REQ-034 SHALL cover the latency check with the macro defined: model core latency set to 13 -> o_err_latency=1 and held; with the macro undefined, o_err_latency stays 0.
REQ-035 SHALL cover simultaneous accept and response at counter=3 -> counter stays 3 and o_busy stays high.
